// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state encoding and
// requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage.
// Data accesses win ties unless fetch has already waited FAIR_MAX data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int FAIR_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_done,
    output logic              stall_f,
    output logic              stall_m
);

    localparam logic [3:0] FAIR_MAX_C = 4'(FAIR_MAX);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [3:0]        r_fair_cnt;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;

    logic w_if_elig;
    logic w_d_elig;
    logic w_grant_valid;
    logic w_grant_id;
    logic w_m_valid;
    logic w_done_i;
    logic w_done_d;

    // A requester being acked this cycle is not asking for a new transaction yet.
    assign w_if_elig     = if_req & ~r_if_ack;
    assign w_d_elig      = d_req & ~r_d_ack;
    assign w_grant_valid = (r_state == IDLE) & (w_if_elig | w_d_elig);
    assign w_grant_id    = (w_d_elig & ~(w_if_elig & (r_fair_cnt == FAIR_MAX_C))) ? REQ_D : REQ_I;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the case leaves the
    // output unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = (w_grant_id == REQ_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_m_valid = (r_state == BUSY_I) || (r_state == BUSY_D);
        w_done_i  = (r_state == BUSY_I) && m_done;
        w_done_d  = (r_state == BUSY_D) && m_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_fair_cnt <= '0;
        end else begin
            r_if_ack <= w_done_i;
            r_d_ack  <= w_done_d;
            if (w_done_i) begin
                r_if_rdata <= m_rdata;
            end
            // Store completions leave the last load data in place.
            if (w_done_d && !r_m_we) begin
                r_d_rdata <= m_rdata;
            end
            if (w_grant_valid) begin
                if (w_grant_id == REQ_D) begin
                    r_m_we    <= d_we;
                    r_m_addr  <= d_addr;
                    r_m_wdata <= d_wdata;
                    if (w_if_elig && (r_fair_cnt != FAIR_MAX_C)) begin
                        r_fair_cnt <= r_fair_cnt + 4'd1;
                    end
                end else begin
                    r_m_we     <= 1'b0;
                    r_m_addr   <= if_addr;
                    r_m_wdata  <= '0;
                    r_fair_cnt <= '0;
                end
            end
        end
    end

    assign m_valid  = w_m_valid;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign if_ack   = r_if_ack;
    assign d_ack    = r_d_ack;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign stall_f  = if_req & ~r_if_ack;
    assign stall_m  = d_req & ~r_d_ack;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int FAIR_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;
    logic              stall_f;
    logic              stall_m;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data), the
    // pending ack pulses, the latched read data and the waiting-grant count.
    int          md_own;
    bit          mk_i, mk_d;
    logic [31:0] mr_i, mr_d, ma, mwd;
    bit          mw;
    int          mfair;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .FAIR_MAX(FAIR_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_ack  (if_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_done  (m_done),
        .stall_f (stall_f),
        .stall_m (stall_m)
    );

    task automatic model_reset();
        md_own = 0; mk_i = 0; mk_d = 0; mr_i = '0; mr_d = '0;
        ma = '0; mwd = '0; mw = 0; mfair = 0;
    endtask

    // Advance one clock: the model consumes the inputs presented this cycle,
    // then outputs are sampled 1ns after the edge.
    task automatic tick();
        bit ei, ed, n_ki, n_kd, n_w;
        int n_own, n_fair;
        logic [31:0] n_ri, n_rd, n_a, n_wd;
        ei = if_req && !mk_i;
        ed = d_req && !mk_d;
        n_ki = 0; n_kd = 0; n_own = md_own; n_fair = mfair;
        n_ri = mr_i; n_rd = mr_d; n_a = ma; n_wd = mwd; n_w = mw;
        if (md_own == 1 && m_done) begin
            n_ki = 1; n_ri = m_rdata; n_own = 0;
        end else if (md_own == 2 && m_done) begin
            n_kd = 1; n_own = 0;
            if (!mw) n_rd = m_rdata;
        end else if (md_own == 0 && (ei || ed)) begin
            if (ed && !(ei && mfair == FAIR_MAX)) begin
                n_own = 2; n_w = d_we; n_a = d_addr; n_wd = d_wdata;
                if (ei && mfair < FAIR_MAX) n_fair = mfair + 1;
            end else begin
                n_own = 1; n_w = 0; n_a = if_addr; n_wd = '0; n_fair = 0;
            end
        end
        @(posedge clk);
        md_own = n_own; mk_i = n_ki; mk_d = n_kd; mr_i = n_ri; mr_d = n_rd;
        ma = n_a; mwd = n_wd; mw = n_w; mfair = n_fair;
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_done = 0; m_rdata = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #7;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL rst_m_we got=%0b exp=0", m_we); end
        checks++; if (m_addr !== 32'h0) begin failures++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
        checks++; if (m_wdata !== 32'h0) begin failures++; $display("FAIL rst_m_wdata got=%h exp=0", m_wdata); end
        checks++; if ({if_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks got=%b exp=00", {if_ack, d_ack}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_after got=%0b exp=0", m_valid); end
    endtask

    task automatic test_fetch_only();
        reset_dut();
        if_req = 1; if_addr = 32'h100;
        #1;
        checks++; if (stall_f !== 1'b1) begin failures++; $display("FAIL fetch_stall_t got=%0b exp=1", stall_f); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin failures++; $display("FAIL fetch_grant got=v%0b a%h w%0b exp=v1 a100 w0", m_valid, m_addr, m_we); end
        checks++; if (stall_f !== 1'b1 || if_ack !== 1'b0) begin failures++; $display("FAIL fetch_stall_t1 got=s%0b k%0b exp=s1 k0", stall_f, if_ack); end
        m_done = 1; m_rdata = 32'hE3A00001;
        tick();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hE3A00001) begin failures++; $display("FAIL fetch_ack got=k%0b d%h exp=k1 dE3A00001", if_ack, if_rdata); end
        checks++; if (stall_f !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL fetch_ack_cycle got=s%0b v%0b exp=s0 v0", stall_f, m_valid); end
        if_req = 0; m_done = 0;
        tick();
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got=%0b exp=0", if_ack); end
    endtask

    task automatic test_store();
        int acks;
        reset_dut();
        acks = 0;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (m_valid !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h200 || m_wdata !== 32'hDEADBEEF) begin
                failures++; $display("FAIL store_hold%0d got=v%0b w%0b a%h d%h exp=v1 w1 a200 dDEADBEEF", k, m_valid, m_we, m_addr, m_wdata);
            end
            if (d_ack) acks++;
            if (k == 2) m_done = 1;
            tick();
        end
        if (d_ack) acks++;
        checks++; if (d_ack !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL store_ack got=k%0b v%0b exp=k1 v0", d_ack, m_valid); end
        d_req = 0; m_done = 0;
        tick();
        if (d_ack) acks++;
        checks++; if (acks != 1) begin failures++; $display("FAIL store_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        tick();
        checks++; if (m_valid !== 1'b1 || m_addr !== 32'h300 || m_we !== 1'b0) begin failures++; $display("FAIL b2b_data_first got=v%0b a%h exp=v1 a300", m_valid, m_addr); end
        m_done = 1; m_rdata = 32'hA5A50001;
        tick();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hA5A50001 || m_valid !== 1'b0) begin failures++; $display("FAIL b2b_data_ack got=k%0b d%h v%0b exp=k1 dA5A50001 v0", d_ack, d_rdata, m_valid); end
        checks++; if (stall_f !== 1'b1 || stall_m !== 1'b0) begin failures++; $display("FAIL b2b_stalls got=f%0b m%0b exp=f1 m0", stall_f, stall_m); end
        d_req = 0; m_done = 0;
        tick();
        checks++; if (m_valid !== 1'b1 || m_addr !== 32'h104 || m_we !== 1'b0) begin failures++; $display("FAIL b2b_fetch_next got=v%0b a%h exp=v1 a104", m_valid, m_addr); end
        m_done = 1; m_rdata = 32'h0BADF00D;
        tick();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_fetch_ack got=k%0b d%h exp=k1 d0BADF00D", if_ack, if_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_starvation();
        reset_dut();
        // Fetch withdraws while waiting, so each data grant is taken with fetch eligible.
        for (int i = 0; i < FAIR_MAX; i++) begin
            if_req = 1; if_addr = 32'h400;
            d_req = 1; d_we = 0; d_addr = 32'h500 + i;
            tick();
            checks++; if (m_addr !== 32'h500 + i) begin failures++; $display("FAIL starve_data%0d got=%h exp=%h", i, m_addr, 32'h500 + i); end
            if_req = 0; m_done = 1;
            tick();
            d_req = 0; m_done = 0;
            tick();
        end
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_addr = 32'h5FF;
        tick();
        checks++; if (m_addr !== 32'h400 || m_valid !== 1'b1) begin failures++; $display("FAIL starve_fetch got=v%0b a%h exp=v1 a400", m_valid, m_addr); end
        d_req = 0; m_done = 1;
        tick();
        if_req = 0; m_done = 0;
        tick();
        if_req = 1; d_req = 1; d_addr = 32'h600;
        tick();
        checks++; if (m_addr !== 32'h600) begin failures++; $display("FAIL starve_cnt_cleared got=%h exp=600", m_addr); end
        if_req = 0; m_done = 1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        d_req = 1; d_we = 1; d_addr = 32'h2A0; d_wdata = 32'h12345678;
        tick();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%0b exp=1", m_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_we !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            failures++; $display("FAIL rmid_async got=v%0b w%0b a%h d%h exp=all0", m_valid, m_we, m_addr, m_wdata);
        end
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (m_valid !== 1'b0 || d_ack !== 1'b0 || if_ack !== 1'b0) begin failures++; $display("FAIL rmid_idle%0d got=v%0b k%0b%0b exp=v0 k00", k, m_valid, if_ack, d_ack); end
            m_done = 1'($urandom_range(0, 1));
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        reset_dut();
        if_req = 1; if_addr = 32'h600;
        tick();
        if_req = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (m_valid !== 1'b1 || m_addr !== 32'h600) begin failures++; $display("FAIL flush_hold%0d got=v%0b a%h exp=v1 a600", k, m_valid, m_addr); end
        end
        m_done = 1; m_rdata = 32'hCAFE0600;
        tick();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hCAFE0600) begin failures++; $display("FAIL flush_ack got=k%0b d%h exp=k1 dCAFE0600", if_ack, if_rdata); end
        m_done = 0; d_req = 1; d_we = 0; d_addr = 32'h700;
        tick();
        checks++; if (m_valid !== 1'b1 || m_addr !== 32'h700) begin failures++; $display("FAIL flush_next_d got=v%0b a%h exp=v1 a700", m_valid, m_addr); end
        m_done = 1; m_rdata = 32'h77770700;
        tick();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h77770700) begin failures++; $display("FAIL flush_d_ack got=k%0b d%h exp=k1 d77770700", d_ack, d_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int bad;
        reset_dut();
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            m_done  = ($urandom_range(0, 9) < 4);
            m_rdata = $urandom;
            if (!if_req || mk_i) begin
                if_req = ($urandom_range(0, 3) == 0);
                if_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 0;
            end
            if (!d_req || mk_d) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
            tick();
            checks++;
            if (m_valid !== (md_own != 0) || if_ack !== mk_i || d_ack !== mk_d
                || if_rdata !== mr_i || d_rdata !== mr_d
                || stall_f !== (if_req && !mk_i) || stall_m !== (d_req && !mk_d)
                || (md_own != 0 && (m_addr !== ma || m_we !== mw || (mw && m_wdata !== mwd)))) begin
                failures++;
                if (bad < 10) $display("FAIL rand_cycle%0d got=v%0b k%0b%0b a%h w%0b ri%h rd%h exp=v%0b k%0b%0b a%h w%0b ri%h rd%h",
                    c, m_valid, if_ack, d_ack, m_addr, m_we, if_rdata, d_rdata,
                    md_own != 0, mk_i, mk_d, ma, mw, mr_i, mr_d);
                bad++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_fetch_only();
        test_store();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
